free_list: RTL and testbench

- Circular FIFO of free physical register tags for the rename stage. Hands out a free PRF tag for each renamed destination register.
- Reclaims the previous physical tag of each committing destination register, i.e. the tag being overwritten in the committed architectural map.
- On a branch-mispredict flush, restores the read pointer to its committed position, so every tag allocated by squashed instructions becomes free again in one cycle.
- Sits between the rename map table (consumer of tags) and the commit-side architectural map (producer of freed tags).

---
 rtl/free_list_if.sv | 25 ++
 rtl/free_list.sv | 55 +++++
 tb/tb_free_list.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename/commit handshake bundle for the physical-tag free list.
// The free list is the slave; the rename/commit logic is the master.
interface free_list_if #(
  parameter int TAG_W = 4
);
  logic             alloc_req;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_fire;
  logic             rel_valid;
  logic [TAG_W-1:0] rel_tag;
  logic             flush;
  logic [TAG_W:0]   free_count;
  logic             err_overflow;

  modport slave (
    input  alloc_req, rel_valid, rel_tag, flush,
    output alloc_ready, alloc_tag, alloc_fire, free_count, err_overflow
  );

  modport master (
    output alloc_req, rel_valid, rel_tag, flush,
    input  alloc_ready, alloc_tag, alloc_fire, free_count, err_overflow
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: spec read pointer for rename,
// committed read pointer for mispredict recovery, write pointer for reclaimed tags.
module free_list #(
  parameter int NUM_AREG = 8,
  parameter int NUM_PREG = 16,
  parameter int TAG_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl
);
  localparam int PW = TAG_W + 1;

  logic [NUM_PREG-1:0][TAG_W-1:0] mem;
  logic [PW-1:0] head, tail, chead;
  logic [PW-1:0] count, chead_nxt;
  logic          full, empty, fire, rel_ok;

  // Wrap bit disambiguates full from empty when low bits match.
  assign count     = tail - head;
  assign full      = (tail[TAG_W-1:0] == head[TAG_W-1:0]) && (tail[TAG_W] != head[TAG_W]);
  assign empty     = (tail == head);
  assign fire      = fl.alloc_req && !empty && !fl.flush;
  assign rel_ok    = fl.rel_valid && !full;
  assign chead_nxt = chead + {{(PW-1){1'b0}}, rel_ok};

  assign fl.alloc_ready = !empty;
  assign fl.alloc_tag   = mem[head[TAG_W-1:0]];
  assign fl.alloc_fire  = fire;
  assign fl.free_count  = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++)
        mem[i] <= (i < NUM_PREG - NUM_AREG) ? TAG_W'(NUM_AREG + i) : '0;
      head            <= '0;
      chead           <= '0;
      tail            <= PW'(NUM_PREG - NUM_AREG);
      fl.err_overflow <= 1'b0;
    end else begin
      if (rel_ok) begin
        mem[tail[TAG_W-1:0]] <= fl.rel_tag;
        tail                 <= tail + 1'b1;
      end
      chead <= chead_nxt;
      // Flush rewinds to the committed position, including this cycle's commit.
      if (fl.flush)
        head <= chead_nxt;
      else if (fire)
        head <= head + 1'b1;
      if (fl.rel_valid && full)
        fl.err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: vector table for alloc/empty/release basics,
// hand sequences for flush, wrap-around streaming, overflow and async reset.
module tb_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  free_list_if #(.TAG_W(4)) bus ();

  free_list #(.NUM_AREG(8), .NUM_PREG(16), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       req;
    bit       rv;
    bit [3:0] rt;
    bit       fl;
    bit       e_fire;
    bit       e_rdy;
    bit [3:0] e_tag;
    bit [4:0] e_cnt;
    bit       e_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs shortly after a rising edge, then sample at the falling edge.
  task automatic apply(input bit rq, input bit rv, input bit [3:0] rt, input bit fl);
    bus.alloc_req = rq;
    bus.rel_valid = rv;
    bus.rel_tag   = rt;
    bus.flush     = fl;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.alloc_req = 1'b0; bus.rel_valid = 1'b0; bus.rel_tag = '0; bus.flush = 1'b0;
    #1;
    chk("async_rst_count", bus.free_count, 8);
    chk("async_rst_tag",   bus.alloc_tag, 8);
    chk("async_rst_ready", bus.alloc_ready, 1);
    chk("async_rst_err",   bus.err_overflow, 0);
    #1 rst = 1'b0;
    tick();
  endtask

  vec_t vt[$];
  int   q[$];
  int   exp_t;

  initial begin
    bus.alloc_req = 1'b0; bus.rel_valid = 1'b0; bus.rel_tag = '0; bus.flush = 1'b0;
    #12 rst = 1'b0;
    tick();

    // Reset state, drain 8 tags, empty behaviour, release into empty.
    vt.push_back('{0,0,0,0, 0,1,8,8,0});
    for (int i = 0; i < 8; i++)
      vt.push_back('{1,0,0,0, 1,1,4'(8+i),5'(8-i),0});
    vt.push_back('{1,0,0,0, 0,0,0,0,0});
    vt.push_back('{1,1,3,0, 0,0,0,0,0});
    vt.push_back('{0,0,0,0, 0,1,3,1,0});
    vt.push_back('{1,0,0,0, 1,1,3,1,0});
    vt.push_back('{0,0,0,0, 0,0,0,0,0});

    foreach (vt[i]) begin
      apply(vt[i].req, vt[i].rv, vt[i].rt, vt[i].fl);
      chk($sformatf("vec%0d_fire", i),  bus.alloc_fire,   vt[i].e_fire);
      chk($sformatf("vec%0d_ready", i), bus.alloc_ready,  vt[i].e_rdy);
      chk($sformatf("vec%0d_count", i), bus.free_count,   vt[i].e_cnt);
      chk($sformatf("vec%0d_err", i),   bus.err_overflow, vt[i].e_err);
      if (vt[i].e_rdy)
        chk($sformatf("vec%0d_tag", i), bus.alloc_tag, vt[i].e_tag);
      tick();
    end

    // Flush: allocate 8,9,10, commit one (release tag 1), then flush.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0);
      chk("fl_alloc_tag", bus.alloc_tag, 8 + i);
      tick();
    end
    apply(0, 1, 1, 0);
    chk("fl_pre_rel_count", bus.free_count, 5);
    tick();
    apply(1, 0, 0, 1);
    chk("fl_fire_blocked", bus.alloc_fire, 0);
    chk("fl_pre_count", bus.free_count, 6);
    tick();
    apply(0, 0, 0, 0);
    chk("fl_post_count", bus.free_count, 8);
    chk("fl_post_tag",   bus.alloc_tag, 9);
    tick();

    // Streaming alloc+release for 20 cycles; head wraps past 16.
    do_reset();
    q.delete();
    for (int i = 8; i < 16; i++) q.push_back(i);
    for (int i = 0; i < 20; i++) begin
      int rt;
      rt = (i * 5 + 2) % 16;
      apply(1, 1, 4'(rt), 0);
      exp_t = q.pop_front();
      q.push_back(rt);
      chk($sformatf("str%0d_tag", i),   bus.alloc_tag, exp_t);
      chk($sformatf("str%0d_fire", i),  bus.alloc_fire, 1);
      chk($sformatf("str%0d_count", i), bus.free_count, 8);
      tick();
    end
    apply(0, 0, 0, 0);
    chk("str_end_count", bus.free_count, 8);
    chk("str_end_tag",   bus.alloc_tag, q[0]);
    tick();

    // Overflow: fill to 16, then release while full (alone and with alloc).
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 4'(i), 0);
      tick();
    end
    apply(0, 1, 4'hF, 0);
    chk("ov_full_count", bus.free_count, 16);
    chk("ov_err_before", bus.err_overflow, 0);
    tick();
    apply(1, 1, 4'hE, 0);
    chk("ov_err_set",     bus.err_overflow, 1);
    chk("ov_count_held",  bus.free_count, 16);
    chk("ov_alloc_fire",  bus.alloc_fire, 1);
    chk("ov_alloc_tag",   bus.alloc_tag, 8);
    tick();
    apply(0, 0, 0, 0);
    chk("ov_count_after", bus.free_count, 15);
    chk("ov_err_sticky",  bus.err_overflow, 1);
    tick();
    // Dropped writes must not appear: remaining order is 9..15 then 0..7.
    for (int i = 0; i < 15; i++) begin
      apply(1, 0, 0, 0);
      chk($sformatf("ov_drain%0d", i), bus.alloc_tag, (i < 7) ? 9 + i : i - 7);
      tick();
    end
    apply(0, 0, 0, 0);
    chk("ov_drained_ready", bus.alloc_ready, 0);
    chk("ov_err_still",     bus.err_overflow, 1);
    tick();

    // Mid-stream async reset clears everything including the sticky error.
    do_reset();
    apply(0, 0, 0, 0);
    chk("post_rst_count", bus.free_count, 8);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
